// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Optional feature macro used by this slice: PC_MISALIGN_TRAP_EN.
package pc_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INSN_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    HOLD
  } fetch_state_e;

  typedef enum logic [1:0] {
    NONE,
    JMP,
    BR,
    TRAP
  } redirect_src_e;

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect arbiter: trap > branch > jump. Produces the winning source,
// its target and the pipeline flush bits.
// With PC_MISALIGN_TRAP_EN defined, a misaligned branch/jump target is
// replaced by the trap vector and flagged; otherwise its low bits are cleared.
module pc_redirect_arb
  import pc_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            trap,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp,
  input  logic [XLEN-1:0] jmp_target,
  output redirect_src_e   src,
  output logic [XLEN-1:0] target,
  output logic            flush_if,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misalign,
`endif
  output logic            flush_id
);

  logic [XLEN-1:0] raw_target;

  // Priority selection of the redirect source and its raw target
  always_comb begin
    src        = NONE;
    raw_target = jmp_target;
    if (trap) begin
      src        = TRAP;
      raw_target = TRAP_VEC;
    end else if (br_taken) begin
      src        = BR;
      raw_target = br_target;
    end else if (jmp) begin
      src        = JMP;
      raw_target = jmp_target;
    end
  end

  // Final target, flush bits and alignment handling for the winner
  always_comb begin
    target   = raw_target;
    flush_if = 1'b0;
    flush_id = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    misalign = 1'b0;
`endif
    unique case (src)
      TRAP: begin
        target   = TRAP_VEC;
        flush_if = 1'b1;
        flush_id = 1'b1;
      end
      BR, JMP: begin
        flush_if = 1'b1;
        flush_id = (src == BR);
`ifdef PC_MISALIGN_TRAP_EN
        if (raw_target[1:0] != 2'b00) begin
          target   = TRAP_VEC;
          flush_id = 1'b1;
          misalign = 1'b1;
        end
`else
        target = raw_target & ~XLEN'(3);
`endif
      end
      default: begin
        target = raw_target;
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives the imem req/ack handshake and
// applies redirects from trap / branch / jump with flushes to IF/ID and ID/EX.
// Optional feature macro: PC_MISALIGN_TRAP_EN (adds misalign_o).
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            trap_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            jmp_i,
  input  logic [XLEN-1:0] jmp_target_i,
  input  logic            imem_ack_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_valid_o,
  output logic            flush_if_o,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misalign_o,
`endif
  output logic            flush_id_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] pc_inc;

  redirect_src_e   rd_src;
  logic [XLEN-1:0] rd_target;
  logic            rd_flush_if;
  logic            rd_flush_id;
  logic            redirect;
`ifdef PC_MISALIGN_TRAP_EN
  logic            rd_misalign;
`endif

  pc_redirect_arb #(
    .TRAP_VEC (TRAP_VEC)
  ) u_arb (
    .trap       (trap_i),
    .br_taken   (br_taken_i),
    .br_target  (br_target_i),
    .jmp        (jmp_i),
    .jmp_target (jmp_target_i),
    .src        (rd_src),
    .target     (rd_target),
    .flush_if   (rd_flush_if),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign   (rd_misalign),
`endif
    .flush_id   (rd_flush_id)
  );

  assign redirect = (rd_src != NONE);
  assign pc_inc   = pc_q + XLEN'(INSN_BYTES);

  // State, PC and request-address registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state, next-PC and next-request-address selection
  // DRAIN keeps the old address on the bus while pc_q already holds the
  // redirect target; the target is only copied to addr on the drain ack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) begin
          pc_d   = rd_target;
          addr_d = rd_target;
        end else begin
          addr_d = pc_q;
        end
      end
      REQ: begin
        if (imem_ack_i) begin
          if (redirect) begin
            pc_d   = rd_target;
            addr_d = rd_target;
          end else if (stall_i) begin
            state_d = HOLD;
          end else begin
            pc_d   = pc_inc;
            addr_d = pc_inc;
          end
        end else if (redirect) begin
          pc_d    = rd_target;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_d = rd_target;
        end
        if (imem_ack_i) begin
          state_d = REQ;
          addr_d  = redirect ? rd_target : pc_q;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = rd_target;
          addr_d  = rd_target;
          state_d = REQ;
        end else if (!stall_i) begin
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake, fetch-valid and flush outputs
  always_comb begin
    imem_req_o    = (state_q == REQ) || (state_q == DRAIN);
    fetch_valid_o = rst && (state_q == REQ) && imem_ack_i && !stall_i && !redirect;
    flush_if_o    = rst && rd_flush_if;
    flush_id_o    = rst && rd_flush_id;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_o    = rst && rd_misalign;
`endif
  end

  assign imem_addr_o = addr_q;
  assign pc_o        = pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; follows PC_MISALIGN_TRAP_EN if defined.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        trap_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        jmp_i;
  logic [31:0] jmp_target_i;
  logic        imem_ack_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] pc_o;
  logic        fetch_valid_o;
  logic        flush_if_o;
  logic        flush_id_o;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int vectors;
  int miscompares;

  pc_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .TRAP_VEC (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .trap_i        (trap_i),
    .br_taken_i    (br_taken_i),
    .br_target_i   (br_target_i),
    .jmp_i         (jmp_i),
    .jmp_target_i  (jmp_target_i),
    .imem_ack_i    (imem_ack_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .pc_o          (pc_o),
    .fetch_valid_o (fetch_valid_o),
    .flush_if_o    (flush_if_o),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign_o    (misalign_o),
`endif
    .flush_id_o    (flush_id_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_i      = 1'b0;
    trap_i       = 1'b0;
    br_taken_i   = 1'b0;
    br_target_i  = 32'h0;
    jmp_i        = 1'b0;
    jmp_target_i = 32'h0;
    imem_ack_i   = 1'b0;
  endtask

  // Reset then one edge out of IDLE, leaving the DUT in REQ at 0x0.
  task automatic apply_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    trap_i      = 1'b1;
    br_taken_i  = 1'b1;
    br_target_i = 32'h200;
    #1;
    vectors++;
    if (pc_o !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want %h", pc_o, 32'h0); end
    vectors++;
    if (imem_addr_o !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h want %h", imem_addr_o, 32'h0); end
    vectors++;
    if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", imem_req_o); end
    vectors++;
    if (fetch_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_fv got %b want 0", fetch_valid_o); end
    vectors++;
    if ({flush_if_o, flush_id_o} !== 2'b00) begin miscompares++; $display("FAIL reset_flush got %b%b want 00", flush_if_o, flush_id_o); end
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL idle_req got %b want 0", imem_req_o); end
    tick();
    vectors++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      miscompares++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_sequential();
    imem_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (fetch_valid_o !== 1'b1 || pc_o !== 32'(i * 4) || imem_addr_o !== 32'(i * 4)) begin
        miscompares++;
        $display("FAIL seq_%0d got fv=%b pc=%h addr=%h want fv=1 pc=%h", i, fetch_valid_o, pc_o, imem_addr_o, 32'(i * 4));
      end
      tick();
    end
    imem_ack_i = 1'b0;
    #1;
    vectors++;
    if (pc_o !== 32'h10 || fetch_valid_o !== 1'b0 || imem_req_o !== 1'b1) begin
      miscompares++; $display("FAIL seq_end got pc=%h fv=%b req=%b want pc=10 fv=0 req=1", pc_o, fetch_valid_o, imem_req_o);
    end
  endtask

  task automatic test_stall_hold();
    apply_reset();
    imem_ack_i = 1'b1;
    tick();
    tick();
    stall_i = 1'b1;
    #1;
    vectors++;
    if (pc_o !== 32'h8 || fetch_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL stall_ack got pc=%h fv=%b want pc=8 fv=0", pc_o, fetch_valid_o);
    end
    tick();
    imem_ack_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (imem_req_o !== 1'b0 || pc_o !== 32'h8) begin
        miscompares++; $display("FAIL hold_%0d got req=%b pc=%h want req=0 pc=8", i, imem_req_o, pc_o);
      end
      tick();
    end
    stall_i = 1'b0;
    tick();
    vectors++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8 || pc_o !== 32'h8) begin
      miscompares++; $display("FAIL refetch got req=%b addr=%h pc=%h want req=1 addr=8 pc=8", imem_req_o, imem_addr_o, pc_o);
    end
    imem_ack_i = 1'b1;
    #1;
    vectors++;
    if (fetch_valid_o !== 1'b1) begin miscompares++; $display("FAIL refetch_fv got %b want 1", fetch_valid_o); end
    tick();
    imem_ack_i = 1'b0;
    vectors++;
    if (pc_o !== 32'hC) begin miscompares++; $display("FAIL after_refetch got pc=%h want c", pc_o); end
  endtask

  task automatic test_redirect_drain();
    br_taken_i   = 1'b1;
    br_target_i  = 32'h200;
    jmp_i        = 1'b1;
    jmp_target_i = 32'h300;
    #1;
    vectors++;
    if ({flush_if_o, flush_id_o, fetch_valid_o} !== 3'b110) begin
      miscompares++; $display("FAIL br_flush got if=%b id=%b fv=%b want 1 1 0", flush_if_o, flush_id_o, fetch_valid_o);
    end
    tick();
    clear_inputs();
    #1;
    vectors++;
    if (pc_o !== 32'h200 || imem_addr_o !== 32'hC || imem_req_o !== 1'b1) begin
      miscompares++; $display("FAIL drain got pc=%h addr=%h req=%b want pc=200 addr=c req=1", pc_o, imem_addr_o, imem_req_o);
    end
    jmp_i        = 1'b1;
    jmp_target_i = 32'h280;
    #1;
    vectors++;
    if ({flush_if_o, flush_id_o} !== 2'b10) begin
      miscompares++; $display("FAIL jmp_flush got if=%b id=%b want 1 0", flush_if_o, flush_id_o);
    end
    tick();
    clear_inputs();
    #1;
    vectors++;
    if (pc_o !== 32'h280 || imem_addr_o !== 32'hC) begin
      miscompares++; $display("FAIL drain_redirect got pc=%h addr=%h want pc=280 addr=c", pc_o, imem_addr_o);
    end
    imem_ack_i = 1'b1;
    #1;
    vectors++;
    if (fetch_valid_o !== 1'b0) begin miscompares++; $display("FAIL drain_fv got %b want 0", fetch_valid_o); end
    tick();
    imem_ack_i = 1'b0;
    #1;
    vectors++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h280 || pc_o !== 32'h280) begin
      miscompares++; $display("FAIL post_drain got req=%b addr=%h pc=%h want req=1 addr=280 pc=280", imem_req_o, imem_addr_o, pc_o);
    end
  endtask

  task automatic test_trap_priority();
    trap_i      = 1'b1;
    br_taken_i  = 1'b1;
    br_target_i = 32'h200;
    stall_i     = 1'b1;
    imem_ack_i  = 1'b1;
    #1;
    vectors++;
    if ({flush_if_o, flush_id_o, fetch_valid_o} !== 3'b110) begin
      miscompares++; $display("FAIL trap_flush got if=%b id=%b fv=%b want 1 1 0", flush_if_o, flush_id_o, fetch_valid_o);
    end
    tick();
    clear_inputs();
    #1;
    vectors++;
    if (pc_o !== 32'h100 || imem_addr_o !== 32'h100 || imem_req_o !== 1'b1) begin
      miscompares++; $display("FAIL trap_pc got pc=%h addr=%h req=%b want pc=100 addr=100 req=1", pc_o, imem_addr_o, imem_req_o);
    end
  endtask

  task automatic test_wrap();
    jmp_i        = 1'b1;
    jmp_target_i = 32'hFFFF_FFFC;
    imem_ack_i   = 1'b1;
    tick();
    jmp_i = 1'b0;
    #1;
    vectors++;
    if (pc_o !== 32'hFFFF_FFFC || fetch_valid_o !== 1'b1) begin
      miscompares++; $display("FAIL wrap_start got pc=%h fv=%b want pc=fffffffc fv=1", pc_o, fetch_valid_o);
    end
    tick();
    imem_ack_i = 1'b0;
    #1;
    vectors++;
    if (pc_o !== 32'h0 || imem_addr_o !== 32'h0) begin
      miscompares++; $display("FAIL wrap got pc=%h addr=%h want 0 0", pc_o, imem_addr_o);
    end
  endtask

  task automatic test_misalign();
    jmp_i        = 1'b1;
    jmp_target_i = 32'h202;
    imem_ack_i   = 1'b1;
    #1;
`ifdef PC_MISALIGN_TRAP_EN
    vectors++;
    if ({misalign_o, flush_if_o, flush_id_o} !== 3'b111) begin
      miscompares++; $display("FAIL misalign_pulse got mis=%b if=%b id=%b want 1 1 1", misalign_o, flush_if_o, flush_id_o);
    end
`else
    vectors++;
    if ({flush_if_o, flush_id_o} !== 2'b10) begin
      miscompares++; $display("FAIL misjmp_flush got if=%b id=%b want 1 0", flush_if_o, flush_id_o);
    end
`endif
    tick();
    clear_inputs();
    #1;
`ifdef PC_MISALIGN_TRAP_EN
    vectors++;
    if (pc_o !== 32'h100 || misalign_o !== 1'b0) begin
      miscompares++; $display("FAIL misalign_pc got pc=%h mis=%b want pc=100 mis=0", pc_o, misalign_o);
    end
`else
    vectors++;
    if (pc_o !== 32'h200 || imem_addr_o !== 32'h200) begin
      miscompares++; $display("FAIL align_pc got pc=%h addr=%h want 200 200", pc_o, imem_addr_o);
    end
`endif
  endtask

  task automatic test_reset_mid_request();
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (pc_o !== 32'h0 || imem_req_o !== 1'b0 || imem_addr_o !== 32'h0) begin
      miscompares++; $display("FAIL midreset got pc=%h req=%b addr=%h want 0 0 0", pc_o, imem_req_o, imem_addr_o);
    end
    tick();
    rst        = 1'b1;
    imem_ack_i = 1'b1;
    #1;
    vectors++;
    if (fetch_valid_o !== 1'b0) begin miscompares++; $display("FAIL idle_ack_fv got %b want 0", fetch_valid_o); end
    tick();
    vectors++;
    if (pc_o !== 32'h0 || imem_addr_o !== 32'h0 || fetch_valid_o !== 1'b1) begin
      miscompares++; $display("FAIL restart got pc=%h addr=%h fv=%b want 0 0 1", pc_o, imem_addr_o, fetch_valid_o);
    end
    tick();
    imem_ack_i = 1'b0;
    vectors++;
    if (pc_o !== 32'h4) begin miscompares++; $display("FAIL restart_adv got pc=%h want 4", pc_o); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_sequential();
    test_stall_hold();
    test_redirect_drain();
    test_trap_priority();
    test_wrap();
    test_misalign();
    test_reset_mid_request();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-stage sequencer for the 32-bit RISC-V pipeline: owns the program-counter register and decides each cycle whether it holds, advances by 4, or is redirected. It arbitrates redirect requests from the trap logic, the EX-stage branch resolver and the ID-stage jump decoder. It drives a req/ack instruction-memory handshake, and emits IF/ID flushes and a fetch-valid strobe to the IF/ID pipeline register.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- TRAP_VEC, 32'h0000_0100, redirect target for traps

Ports:
- clk  in  1  pipeline clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- stall_i  in  1  hazard-unit stall, PC must not advance
- trap_i  in  1  trap request, highest priority
- br_taken_i  in  1  EX-stage branch resolved taken
- br_target_i  in  32  branch target
- jmp_i  in  1  ID-stage JAL/JALR decoded
- jmp_target_i  in  32  jump target
- imem_ack_i  in  1  instruction memory completes current request
- imem_req_o  out  1  fetch request, held until ack
- imem_addr_o  out  32  fetch address, stable while req high
- pc_o  out  32  current PC register
- fetch_valid_o  out  1  fetched word is valid for IF/ID this cycle
- flush_if_o  out  1  kill IF/ID contents
- flush_id_o  out  1  kill ID/EX contents
- misalign_o  out  1  misaligned-target pulse (only with PC_MISALIGN_TRAP_EN)

## Operation
- Redirect priority: trap > branch > jump. The winner is "redirect", with target TRAP_VEC, br_target_i or jmp_target_i.
- Flushes are combinational from inputs, forced 0 while rst is low:
  - trap or branch: flush_if_o = flush_id_o = 1
  - jump only: flush_if_o = 1
- Sequential advance is pc_o + 4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- IDLE (reset state): imem_req_o = 0. Next cycle go to REQ, or load the target if a redirect is present.
- REQ: imem_req_o = 1, imem_addr_o = request-address register.
  - ack, no stall, no redirect: fetch_valid_o = 1; pc_o += 4; new request issued at the new PC. Back-to-back fetches are allowed.
  - ack and stall, no redirect: word discarded; pc_o held; go to HOLD.
  - ack and redirect: word discarded; pc_o = target; REQ at target.
  - no ack and redirect: pc_o = target; go to DRAIN. The old address stays on imem_addr_o.
  - no ack, no redirect: stay in REQ, independent of stall.
- DRAIN: imem_req_o = 1 at the old address; fetch_valid_o = 0.
  - On ack, go to REQ at pc_o.
  - A newer redirect in DRAIN overwrites pc_o, highest priority wins, and the state stays DRAIN.
- HOLD: imem_req_o = 0.
  - stall low: go to REQ and refetch pc_o.
  - redirect (which overrides stall): pc_o = target, go to REQ.
- A redirect always overrides stall.
- fetch_valid_o is never asserted in the same cycle as any flush.
- Reset mid-request: everything returns immediately to reset values. An ack from the abandoned request is ignored in IDLE.

## Timing
- Reset values:
  - pc_o = RESET_PC, state = IDLE
  - imem_req_o = 0, imem_addr_o = RESET_PC
  - fetch_valid_o = 0, flushes = 0, misalign_o = 0
- Registered signals: pc_o, request-address register, state. imem_req_o decodes from state only.
- Combinational from the current cycle: fetch_valid_o (ack qualified by state, stall and redirect), flushes, misalign_o.
- Redirect latency: target appears on pc_o one edge after the redirect input. It appears on imem_addr_o in that cycle if no request was outstanding, otherwise the cycle after the drain ack.
- Minimum fetch period: 1 cycle per instruction with single-cycle ack.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A winning branch/jump target with bits[1:0] != 0 is replaced by TRAP_VEC.
  - flush_if_o and flush_id_o are both asserted.
  - misalign_o pulses for that cycle.
- Undefined: target bits[1:0] are forced to 2'b00, and the misalign_o port is absent.

## Structure
- Shared package pc_ctrl_pkg holds:
  - state enum {IDLE, REQ, DRAIN, HOLD}
  - redirect-source enum {NONE, JMP, BR, TRAP}
  - XLEN = 32 and INSN_BYTES = 4
- One combinational sub-module, pc_redirect_arb: takes trap/branch/jump plus targets and returns source, target and flush bits (and the misalign check when enabled).

## Test plan
- Reset release, ack held 1 for 4 cycles -> pc_o sequence 0x0, 0x4, 0x8, 0xC; fetch_valid_o high 4 cycles.
- Stall during ack at PC 0x8, stall held 3 cycles -> word discarded, HOLD, pc_o stays 0x8, refetch 0x8 after stall drops.
- br_taken_i (0x200) and jmp_i (0x300) in the same cycle while a request is outstanding -> DRAIN at old address, both flushes, pc_o = 0x200, next request at 0x200.
- trap_i with br_taken_i and stall_i all high -> pc_o = 0x100, both flushes, no fetch_valid_o.
- Run from pc_o = 0xFFFF_FFFC with ack -> pc_o wraps to 0x0000_0000.
- With PC_MISALIGN_TRAP_EN: jump target 0x202 -> misalign_o pulse, pc_o = 0x100. Without the macro: pc_o = 0x200.
